pipe_skid_stage: RTL

- Parametrised successor to the fixed ID/EX-style pipeline register: a generic inter-stage register with a valid/ready handshake, a two-entry skid buffer, a synchronous flush, and bubble insertion.
- Instantiated between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Separates the payload into a data field and a control field. The control field is forced to zero whenever the stage holds no valid entry, so downstream logic always sees a NOP.
- Breaks the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_skid_stage.sv | 88 ++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, default widths and control-bit positions for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 128;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    // Control-field bit positions; ALUCtrl occupies CTRL_ALUCTRL_LSB +: CTRL_ALUCTRL_W
    localparam int CTRL_ALUSRC      = 0;
    localparam int CTRL_ALUCTRL_LSB = 1;
    localparam int CTRL_ALUCTRL_W   = 4;
    localparam int CTRL_REGDST      = 5;
    localparam int CTRL_JUMP        = 6;
    localparam int CTRL_BRANCH      = 7;
    localparam int CTRL_MEMWRITE    = 8;
    localparam int CTRL_MEMREAD     = 9;
    localparam int CTRL_MEMTOREG    = 10;
    localparam int CTRL_REGWRITE    = 11;

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a one-entry skid, flush, bubble NOPs and stall counter
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc, dlv;

    // Ready depends only on registered state, cutting the combinational ready chain
    assign in_ready  = state_q != ST_FULL;
    assign out_valid = state_q != ST_EMPTY;
    assign out_data  = head_data_q;
    assign out_ctrl  = out_valid ? head_ctrl_q : '0;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;
    assign acc       = in_valid & in_ready;
    assign dlv       = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        cnt_d       = (out_valid & ~out_ready & ~flush & (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else if (state_q == ST_FULL) begin
            if (dlv) begin
                head_data_d = skid_data_q;
                head_ctrl_d = skid_ctrl_q;
                state_d     = ST_ONE;
            end
        end else if (acc & (state_q == ST_ONE) & ~dlv) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_FULL;
        end else if (acc) begin
            head_data_d = in_data;
            head_ctrl_d = in_ctrl;
            state_d     = ST_ONE;
        end else if (dlv) begin
            state_d     = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
